// File: rtl/opr_arbiter.sv
// opr_arbiter: two-requester round-robin front end for the shared `operators`
// datapath. One operation is in flight at a time; results come back tagged
// with the requester id.
// Optional feature: define OPR_ARB_STATS_EN to add the stat0/stat1 per-requester
// delivered-result counters (8-bit, saturating).

module operators #(
  parameter int NBIT = 4
) (
  input  logic [NBIT-1:0] a,
  input  logic [NBIT-1:0] b,
  output logic [NBIT:0]   sum,
  output logic [NBIT:0]   sub,
  output logic [NBIT:0]   multi,
  output logic [NBIT:0]   div,
  output logic [NBIT:0]   mod,
  output logic [NBIT:0]   square
);
  logic [2*NBIT-1:0] prod;
  logic [2*NBIT-1:0] sq;
  logic [NBIT-1:0]   quo;
  logic [NBIT-1:0]   rem;

  assign prod   = {{NBIT{1'b0}}, a} * {{NBIT{1'b0}}, b};
  assign sq     = {{NBIT{1'b0}}, a} * {{NBIT{1'b0}}, a};
  // Zero divisor yields 0 here; the arbiter flags it as an error anyway.
  assign quo    = (b == '0) ? '0 : a / b;
  assign rem    = (b == '0) ? '0 : a % b;
  assign sum    = {1'b0, a} + {1'b0, b};
  assign sub    = {1'b0, a} - {1'b0, b};
  assign multi  = prod[NBIT:0];
  assign square = sq[NBIT:0];
  assign div    = {1'b0, quo};
  assign mod    = {1'b0, rem};
endmodule

module opr_arbiter #(
  parameter int NBIT = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [2:0]      req0_op,
  input  logic [NBIT-1:0] req0_a,
  input  logic [NBIT-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [2:0]      req1_op,
  input  logic [NBIT-1:0] req1_a,
  input  logic [NBIT-1:0] req1_b,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [NBIT:0]   res_data,
  output logic            res_id,
  output logic            res_err
`ifdef OPR_ARB_STATS_EN
  ,
  output logic [7:0]      stat0,
  output logic [7:0]      stat1
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t          state;
  logic            last_grant;
  logic [2:0]      op_q;
  logic [NBIT-1:0] a_q;
  logic [NBIT-1:0] b_q;
  logic            id_q;

  logic            any_valid;
  logic            gnt_id;
  logic [NBIT:0]   sum, sub, multi, div, mod, square;
  logic [NBIT:0]   sel_data;
  logic            sel_err;

  operators #(.NBIT(NBIT)) u_operators (
    .a(a_q), .b(b_q),
    .sum(sum), .sub(sub), .multi(multi), .div(div), .mod(mod), .square(square)
  );

  // Round-robin pick: under contention the requester that did not win last time
  // gets the slot; a lone requester always wins.
  assign any_valid  = req0_valid | req1_valid;
  assign gnt_id     = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  // Ready is gated by rstn so nothing looks accepted while reset is held.
  assign req0_ready = rstn & (state == IDLE) & any_valid & ~gnt_id;
  assign req1_ready = rstn & (state == IDLE) & any_valid &  gnt_id;

  // Opcode selects a datapath output; illegal ops and zero divisors force 0/err.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b0;
    case (op_q)
      3'd0: sel_data = sum;
      3'd1: sel_data = sub;
      3'd2: sel_data = multi;
      3'd3: if (b_q == '0) sel_err = 1'b1; else sel_data = div;
      3'd4: if (b_q == '0) sel_err = 1'b1; else sel_data = mod;
      3'd5: sel_data = square;
      default: sel_err = 1'b1;
    endcase
  end

  // Sequencer: accept in IDLE, settle one cycle in EXEC, present in HOLD.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            op_q       <= gnt_id ? req1_op : req0_op;
            a_q        <= gnt_id ? req1_a  : req0_a;
            b_q        <= gnt_id ? req1_b  : req0_b;
            id_q       <= gnt_id;
            last_grant <= gnt_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          res_data  <= sel_data;
          res_id    <= id_q;
          res_err   <= sel_err;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OPR_ARB_STATS_EN
  // Per-requester count of delivered results, sticking at 255.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat0 <= '0;
      stat1 <= '0;
    end else if (res_valid && res_ready) begin
      if (!res_id && stat0 != 8'hFF) stat0 <= stat0 + 8'd1;
      if ( res_id && stat1 != 8'hFF) stat1 <= stat1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_opr_arbiter.sv
// Bench for opr_arbiter: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_opr_arbiter;
  localparam int NBIT = 4;
  localparam int MASK = (1 << (NBIT + 1)) - 1;

  logic            clk = 1'b0;
  logic            rstn;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]      req0_op, req1_op;
  logic [NBIT-1:0] req0_a, req0_b, req1_a, req1_b;
  logic            res_valid, res_ready, res_id, res_err;
  logic [NBIT:0]   res_data;
`ifdef OPR_ARB_STATS_EN
  logic [7:0]      stat0, stat1;
`endif

  always #5 clk = ~clk;

  opr_arbiter #(.NBIT(NBIT)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_err(res_err)
`ifdef OPR_ARB_STATS_EN
    , .stat0(stat0), .stat1(stat1)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight; it is accepted, spends one
  // cycle computing, then is offered until taken.
  bit m_idle, m_exec, m_valid;
  int m_last, m_data, m_id, m_err, m_pd, m_pe, m_pid, m_s0, m_s1;
  bit g_acc0, g_acc1, g_rv;
  int g_rd, g_rid;

  function automatic void ref_result(input int op, input int a, input int b,
                                     output int d, output int e);
    d = 0; e = 0;
    case (op)
      0: d = a + b;
      1: d = a - b;
      2: d = a * b;
      3: if (b == 0) e = 1; else d = a / b;
      4: if (b == 0) e = 1; else d = a % b;
      5: d = a * a;
      default: e = 1;
    endcase
    d = d & MASK;
  endfunction

  task automatic model_reset();
    m_idle = 1; m_exec = 0; m_valid = 0; m_last = 1;
    m_s0 = 0; m_s1 = 0;
  endtask

  // One clock: inputs already applied just after a falling edge.
  task automatic step();
    bit any;
    int gid, e0, e1;
    #1;
    any = m_idle && (req0_valid || req1_valid);
    gid = (req0_valid && req1_valid) ? 1 - m_last : (req1_valid ? 1 : 0);
    e0  = (any && gid == 0) ? 1 : 0;
    e1  = (any && gid == 1) ? 1 : 0;
    check("req0_ready", int'(req0_ready), e0);
    check("req1_ready", int'(req1_ready), e1);
    check("res_valid", int'(res_valid), int'(m_valid));
    if (m_valid) begin
      check("res_data", int'(res_data), m_data);
      check("res_id", int'(res_id), m_id);
      check("res_err", int'(res_err), m_err);
    end
`ifdef OPR_ARB_STATS_EN
    check("stat0", int'(stat0), m_s0);
    check("stat1", int'(stat1), m_s1);
`endif
    g_acc0 = e0[0]; g_acc1 = e1[0];
    g_rv = res_valid; g_rd = int'(res_data); g_rid = int'(res_id);
    if (any) begin
      m_last = gid; m_pid = gid;
      if (gid == 1) ref_result(int'(req1_op), int'(req1_a), int'(req1_b), m_pd, m_pe);
      else          ref_result(int'(req0_op), int'(req0_a), int'(req0_b), m_pd, m_pe);
      m_idle = 0; m_exec = 1;
    end else if (m_exec) begin
      m_exec = 0; m_valid = 1;
      m_data = m_pd; m_err = m_pe; m_id = m_pid;
    end else if (m_valid && res_ready) begin
      m_valid = 0; m_idle = 1;
      if (m_id == 0 && m_s0 < 255) m_s0++;
      if (m_id == 1 && m_s1 < 255) m_s1++;
    end
    @(negedge clk);
  endtask

  task automatic drive(input int rq, input bit v, input int op, input int a, input int b);
    if (rq == 0) begin
      req0_valid = v; req0_op = 3'(op); req0_a = NBIT'(a); req0_b = NBIT'(b);
    end else begin
      req1_valid = v; req1_op = 3'(op); req1_a = NBIT'(a); req1_b = NBIT'(b);
    end
  endtask

  task automatic apply_reset();
    req0_valid = 1; req1_valid = 1;
    rstn = 0;
    #1;
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_res_id", int'(res_id), 0);
    check("rst_res_err", int'(res_err), 0);
    check("rst_req0_ready", int'(req0_ready), 0);
    check("rst_req1_ready", int'(req1_ready), 0);
    model_reset();
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
  endtask

  // Issue one request from a lone requester and check its result and latency.
  task automatic do_req(input int rq, input int op, input int a, input int b,
                        input int exp_d, input int exp_e);
    bit got;
    int n;
    drive(rq, 1, op, a, b);
    res_ready = 1;
    got = 0; n = 0;
    while (!got && n < 10) begin
      step(); n++;
      got = (rq == 1) ? g_acc1 : g_acc0;
    end
    drive(rq, 0, op, a, b);
    if (!got) check("accept_timeout", 0, 1);
    got = 0; n = 0;
    while (!got && n < 10) begin
      step(); n++;
      got = g_rv;
    end
    check("latency", n, 2);
    check("dir_data", g_rd, exp_d);
    check("dir_id", g_rid, rq);
    check("dir_err", int'(res_err), exp_e);
  endtask

  int gq[$], dq[$], iq[$];

  initial begin
    bit got;
    int n;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    res_ready = 0;
    apply_reset();

    // Contention from reset: grants alternate starting with requester 0.
    drive(0, 1, 2, 3, 5);
    drive(1, 1, 5, 3, 0);
    res_ready = 1;
    n = 0;
    while (dq.size() < 4 && n < 30) begin
      step(); n++;
      if (g_acc0) gq.push_back(0);
      if (g_acc1) gq.push_back(1);
      if (g_rv) begin dq.push_back(g_rd); iq.push_back(g_rid); end
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check("cont_count", dq.size(), 4);
    for (int i = 0; i < 4 && i < dq.size() && i < gq.size(); i++) begin
      check("cont_grant", gq[i], i % 2);
      check("cont_data", dq[i], (i % 2 == 1) ? 9 : 15);
      check("cont_id", iq[i], i % 2);
    end
    step(); step();

    do_req(0, 0, 9, 8, 17, 0);
    do_req(1, 3, 7, 0, 0, 1);
    do_req(1, 4, 7, 3, 1, 0);
    do_req(0, 7, 5, 5, 0, 1);
    step();

    // Backpressure: result held, competing request must wait for the handshake.
    res_ready = 0;
    drive(0, 1, 1, 2, 5);
    got = 0; n = 0;
    while (!got && n < 10) begin step(); n++; got = g_acc0; end
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 1);
    for (int i = 0; i < 6; i++) step();
    check("bp_data", g_rd, 29);
    res_ready = 1;
    step();
    step();
    check("bp_next_accept", int'(g_acc1), 1);
    drive(1, 0, 0, 0, 0);
    step(); step(); step();

    // Reset while in EXEC.
    res_ready = 0;
    drive(0, 1, 0, 1, 2);
    got = 0; n = 0;
    while (!got && n < 10) begin step(); n++; got = g_acc0; end
    drive(0, 0, 0, 0, 0);
    apply_reset();

    // Reset while in HOLD: res_valid must fall without a clock edge.
    drive(0, 1, 0, 1, 2);
    got = 0; n = 0;
    while (!got && n < 10) begin step(); n++; got = g_acc0; end
    drive(0, 0, 0, 0, 0);
    step();
    #1;
    check("hold_valid", int'(res_valid), 1);
    apply_reset();

    // last_grant must be back at 1, so requester 0 wins.
    drive(0, 1, 0, 2, 2);
    drive(1, 1, 0, 3, 3);
    res_ready = 1;
    step();
    check("post_rst_grant0", int'(g_acc0), 1);
    drive(0, 0, 0, 0, 0);
    step(); step(); step(); step();
    drive(1, 0, 0, 0, 0);
    step(); step();

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      step();
      if (g_acc0 || (req0_valid && $urandom_range(9) == 0)) req0_valid = 0;
      else if (!req0_valid && $urandom_range(2) == 0)
        drive(0, 1, $urandom_range(7), $urandom_range(15),
              ($urandom_range(3) == 0) ? 0 : $urandom_range(15));
      if (g_acc1 || (req1_valid && $urandom_range(9) == 0)) req1_valid = 0;
      else if (!req1_valid && $urandom_range(2) == 0)
        drive(1, 1, $urandom_range(7), $urandom_range(15),
              ($urandom_range(3) == 0) ? 0 : $urandom_range(15));
      res_ready = ($urandom_range(3) != 0);
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    res_ready = 1;
    for (int i = 0; i < 4; i++) step();

`ifdef OPR_ARB_STATS_EN
    apply_reset();
    for (int i = 0; i < 3; i++) do_req(0, 0, 1, 1, 2, 0);
    for (int i = 0; i < 2; i++) do_req(1, 0, 1, 1, 2, 0);
    step();
    check("stat0_three", int'(stat0), 3);
    check("stat1_two", int'(stat1), 2);
    for (int i = 0; i < 300; i++) do_req(0, 5, 2, 0, 4, 0);
    step();
    check("stat0_sat", int'(stat0), 255);
    check("stat1_kept", int'(stat1), 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end
endmodule
